// File: rtl/code_map_pipe_if.sv
// Streaming + configuration bus for code_map_pipe: table write port, input code
// stream and mapped-output stream, each with valid/ready where applicable.
interface code_map_pipe_if #(
    parameter int SEL_W = 2,
    parameter int OUT_W = 2
);
    logic             cfg_we;
    logic [SEL_W-1:0] cfg_addr;
    logic [OUT_W-1:0] cfg_data;
    logic             cfg_en;

    logic             in_valid;
    logic             in_ready;
    logic [SEL_W-1:0] in_code;

    logic             out_valid;
    logic             out_ready;
    logic [OUT_W-1:0] out_data;
    logic             out_hit;

    modport master (
        output cfg_we, cfg_addr, cfg_data, cfg_en,
        output in_valid, in_code, out_ready,
        input  in_ready, out_valid, out_data, out_hit
    );

    modport slave (
        input  cfg_we, cfg_addr, cfg_data, cfg_en,
        input  in_valid, in_code, out_ready,
        output in_ready, out_valid, out_data, out_hit
    );
endinterface

// File: rtl/code_map_pipe.sv
// Programmable code-to-value mapper with a one-stage registered valid/ready output.
// Optional saturating hit counter enabled by defining CODE_MAP_HITCNT_EN.
module code_map_pipe #(
    parameter int               SEL_W       = 2,
    parameter int               OUT_W       = 2,
    parameter logic [OUT_W-1:0] DEFAULT_VAL = '0
`ifdef CODE_MAP_HITCNT_EN
    ,
    parameter int               CNT_W       = 16
`endif
) (
    input  logic                 clk,
    input  logic                 rst_n,
    code_map_pipe_if.slave       bus
`ifdef CODE_MAP_HITCNT_EN
    ,
    output logic [CNT_W-1:0]     hit_count
`endif
);

    localparam int DEPTH = 2 ** SEL_W;

    logic [OUT_W-1:0] tbl_data_q [DEPTH];
    logic [DEPTH-1:0] tbl_en_q;

    logic             out_valid_q;
    logic [OUT_W-1:0] out_data_q;
    logic             out_hit_q;

    logic             in_ready;
    logic             accept;
    logic             hit_d;
    logic [OUT_W-1:0] data_d;

    assign in_ready = !out_valid_q || bus.out_ready;
    assign accept   = bus.in_valid && in_ready;

    // Lookup reads the registered table, so a same-cycle write lands after the read.
    always_comb begin
        hit_d  = tbl_en_q[bus.in_code];
        data_d = DEFAULT_VAL;
        if (hit_d) begin
            data_d = tbl_data_q[bus.in_code];
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                tbl_data_q[i] <= '0;
            end
            tbl_en_q <= '0;
        end else if (bus.cfg_we) begin
            tbl_data_q[bus.cfg_addr] <= bus.cfg_data;
            tbl_en_q[bus.cfg_addr]   <= bus.cfg_en;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            out_valid_q <= 1'b0;
            out_data_q  <= DEFAULT_VAL;
            out_hit_q   <= 1'b0;
        end else if (accept) begin
            out_valid_q <= 1'b1;
            out_data_q  <= data_d;
            out_hit_q   <= hit_d;
        end else if (bus.out_ready) begin
            out_valid_q <= 1'b0;
        end
    end

    assign bus.in_ready  = in_ready;
    assign bus.out_valid = out_valid_q;
    assign bus.out_data  = out_data_q;
    assign bus.out_hit   = out_hit_q;

`ifdef CODE_MAP_HITCNT_EN
    logic [CNT_W-1:0] hit_count_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            hit_count_q <= '0;
        end else if (accept && hit_d && (hit_count_q != {CNT_W{1'b1}})) begin
            hit_count_q <= hit_count_q + 1'b1;
        end
    end

    assign hit_count = hit_count_q;
`endif

endmodule

// File: tb/tb_code_map_pipe.sv
// Directed bench for code_map_pipe: expected {data,hit} pairs queued at accept
// time and checked by a monitor when each output transfer happens.
module tb_code_map_pipe;

    localparam int SEL_W = 2;
    localparam int OUT_W = 2;
    localparam int CNT_W = 2;

    logic clk = 1'b0;
    logic rst_n = 1'b0;

    always #5 clk = ~clk;

    code_map_pipe_if #(.SEL_W(SEL_W), .OUT_W(OUT_W)) bus ();

`ifdef CODE_MAP_HITCNT_EN
    logic [CNT_W-1:0] hit_count;
    code_map_pipe #(.SEL_W(SEL_W), .OUT_W(OUT_W), .DEFAULT_VAL(2'd0), .CNT_W(CNT_W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .bus       (bus),
        .hit_count (hit_count)
    );
`else
    code_map_pipe #(.SEL_W(SEL_W), .OUT_W(OUT_W), .DEFAULT_VAL(2'd0)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );
`endif

    int n_checks = 0;
    int n_fails  = 0;
    logic [OUT_W:0] sb_q[$];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        assert (got === exp) else begin
            n_fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Monitor: a transfer happens at the next rising edge when valid and ready are both high.
    always @(negedge clk) begin
        if (rst_n && bus.out_valid && bus.out_ready) begin
            if (sb_q.size() == 0) begin
                check("sb_unexpected_output", 32'd1, 32'd0);
            end else begin
                logic [OUT_W:0] e;
                e = sb_q.pop_front();
                check("sb_data", 32'(bus.out_data), 32'(e[OUT_W:1]));
                check("sb_hit", 32'(bus.out_hit), 32'(e[0]));
            end
        end
    end

    task automatic cfg_write(input logic [SEL_W-1:0] a, input logic [OUT_W-1:0] d, input logic en);
        bus.cfg_we = 1'b1;
        bus.cfg_addr = a;
        bus.cfg_data = d;
        bus.cfg_en = en;
        tick();
        bus.cfg_we = 1'b0;
    endtask

    task automatic send(input logic [SEL_W-1:0] code, input logic [OUT_W-1:0] exp_d, input logic exp_h);
        int n;
        n = 0;
        bus.in_valid = 1'b1;
        bus.in_code = code;
        while (!bus.in_ready && n < 50) begin
            tick();
            n++;
        end
        if (!bus.in_ready) begin
            check("send_timeout", 32'd0, 32'd1);
        end
        sb_q.push_back({exp_d, exp_h});
        tick();
        bus.in_valid = 1'b0;
        check("latency_valid", 32'(bus.out_valid), 32'd1);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        bus.cfg_we = 1'b0;
        bus.cfg_addr = '0;
        bus.cfg_data = '0;
        bus.cfg_en = 1'b0;
        bus.in_valid = 1'b0;
        bus.in_code = '0;
        bus.out_ready = 1'b1;

        // Reset state
        rst_n = 1'b0;
        tick();
        tick();
        check("rst_out_valid", 32'(bus.out_valid), 32'd0);
        check("rst_out_data", 32'(bus.out_data), 32'd0);
        check("rst_out_hit", 32'(bus.out_hit), 32'd0);
        check("rst_in_ready", 32'(bus.in_ready), 32'd1);
`ifdef CODE_MAP_HITCNT_EN
        check("rst_hit_count", 32'(hit_count), 32'd0);
`endif
        rst_n = 1'b1;
        tick();

        // Empty table: every code misses
        for (int c = 0; c < 4; c++) begin
            send(SEL_W'(c), 2'd0, 1'b0);
        end
        tick();
        check("drain1_out_valid", 32'(bus.out_valid), 32'd0);

        // Programmed entries
        cfg_write(2'd2, 2'd3, 1'b1);
        cfg_write(2'd3, 2'd2, 1'b1);
        send(2'd0, 2'd0, 1'b0);
        send(2'd1, 2'd0, 1'b0);
        send(2'd2, 2'd3, 1'b1);
        check("direct_code2", 32'(bus.out_data), 32'd3);
        send(2'd3, 2'd2, 1'b1);
        check("direct_code3", 32'(bus.out_data), 32'd2);
        tick();

        // Backpressure: hold output three cycles with the next code waiting
        bus.out_ready = 1'b0;
        send(2'd2, 2'd3, 1'b1);
        bus.in_valid = 1'b1;
        bus.in_code = 2'd3;
        for (int i = 0; i < 3; i++) begin
            check("stall_in_ready", 32'(bus.in_ready), 32'd0);
            check("stall_out_data", 32'(bus.out_data), 32'd3);
            check("stall_out_valid", 32'(bus.out_valid), 32'd1);
            tick();
        end
        bus.out_ready = 1'b1;
        #1;
        check("release_in_ready", 32'(bus.in_ready), 32'd1);
        sb_q.push_back({2'd2, 1'b1});
        tick();
        bus.in_valid = 1'b0;
        check("release_next_data", 32'(bus.out_data), 32'd2);
        check("release_next_valid", 32'(bus.out_valid), 32'd1);
        tick();

        // Same-cycle write and accept on entry 2: old entry used
        bus.cfg_we = 1'b1;
        bus.cfg_addr = 2'd2;
        bus.cfg_data = 2'd1;
        bus.cfg_en = 1'b1;
        bus.in_valid = 1'b1;
        bus.in_code = 2'd2;
        sb_q.push_back({2'd3, 1'b1});
        tick();
        bus.cfg_we = 1'b0;
        bus.in_valid = 1'b0;
        check("rbw_old_value", 32'(bus.out_data), 32'd3);
        send(2'd2, 2'd1, 1'b1);
        check("rbw_new_value", 32'(bus.out_data), 32'd1);
        tick();

        // Reset while stalled with valid output
        bus.out_ready = 1'b0;
        send(2'd3, 2'd2, 1'b1);
        rst_n = 1'b0;
        tick();
        check("midrst_out_valid", 32'(bus.out_valid), 32'd0);
        check("midrst_pending", 32'(sb_q.size()), 32'd1);
        sb_q.delete();
        rst_n = 1'b1;
        bus.out_ready = 1'b1;
        tick();
        send(2'd2, 2'd0, 1'b0);
        check("midrst_table_cleared", 32'(bus.out_data), 32'd0);
        send(2'd3, 2'd0, 1'b0);
        tick();

        // Hit counting and saturation
        cfg_write(2'd1, 2'd1, 1'b1);
        send(2'd1, 2'd1, 1'b1);
        send(2'd1, 2'd1, 1'b1);
`ifdef CODE_MAP_HITCNT_EN
        check("hitcnt_two", 32'(hit_count), 32'd2);
`endif
        for (int i = 0; i < 3; i++) begin
            send(2'd1, 2'd1, 1'b1);
        end
`ifdef CODE_MAP_HITCNT_EN
        check("hitcnt_saturated", 32'(hit_count), 32'd3);
`endif
        send(2'd0, 2'd0, 1'b0);
        send(2'd0, 2'd0, 1'b0);
`ifdef CODE_MAP_HITCNT_EN
        check("hitcnt_after_miss", 32'(hit_count), 32'd3);
`endif
        tick();
        tick();
        check("sb_drained", 32'(sb_q.size()), 32'd0);
        check("final_out_valid", 32'(bus.out_valid), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
